dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_arbiter                                           |
// | Description : Two-requester arbiter in front of a single-port DMEM   |
// |               with combinational read data. Each accepted access     |
// |               occupies one ACCESS cycle followed by at least one     |
// |               IDLE cycle. Round-robin or fixed (A-first) priority.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester A
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  // requester B
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  // DMEM side
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] RF_Rd_data,
  output logic              wen,
  input  logic [DATA_W-1:0] memory_data,
  // status
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                last_b_q, last_b_d;    // 1 = B received the most recent grant
  logic                owner_b_q, owner_b_d;  // 1 = current access belongs to B
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                gnt_a_q, gnt_a_d;
  logic                gnt_b_q, gnt_b_d;
  logic                rvalid_a_q, rvalid_a_d;
  logic                rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;

  logic                any_req;
  logic                pick_b;

  // Winner selection: a lone requester always wins; ties go to A in fixed
  // mode, otherwise to whoever was not granted last.
  always_comb begin
    any_req = req_a | req_b;
    pick_b  = 1'b0;
    if (req_a && req_b) begin
      pick_b = (FIXED_PRI != 0) ? 1'b0 : ~last_b_q;
    end else begin
      pick_b = req_b;
    end
  end

  // Next-state and registered-output logic for the IDLE/ACCESS machine.
  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    owner_b_d  = owner_b_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = ACCESS;
          owner_b_d = pick_b;
          last_b_d  = pick_b;
          we_d      = pick_b ? we_b    : we_a;
          addr_d    = pick_b ? addr_b  : addr_a;
          wdata_d   = pick_b ? wdata_b : wdata_a;
          gnt_a_d   = ~pick_b;
          gnt_b_d   = pick_b;
        end
      end
      ACCESS: begin
        // Requests seen here are ignored; the machine always drops back.
        state_d = IDLE;
        if (!we_q) begin
          if (owner_b_q) begin
            rdata_b_d  = memory_data;
            rvalid_b_d = 1'b1;
          end else begin
            rdata_a_d  = memory_data;
            rvalid_a_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset lands in IDLE with A favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      owner_b_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      owner_b_q  <= owner_b_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  // The latched address/data registers double as the DMEM-side outputs, so
  // they naturally hold their last value outside ACCESS. wen is gated by the
  // state so an asynchronous reset kills a write before the next edge.
  assign busy       = (state_q == ACCESS);
  assign wen        = busy & we_q;
  assign Mem_Addr   = addr_q;
  assign RF_Rd_data = wdata_q;
  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign rvalid_a   = rvalid_a_q;
  assign rvalid_b   = rvalid_b_q;
  assign rdata_a    = rdata_a_q;
  assign rdata_b    = rdata_b_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dmem_arbiter                                        |
// | Description : Directed bench for dmem_arbiter with a DMEM model and  |
// |               grant/read-data scoreboards.                           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, we_a, req_b, we_b;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
  logic        gnt_a, rvalid_a, gnt_b, rvalid_b, wen, busy;
  logic [31:0] rdata_a, rdata_b, Mem_Addr, RF_Rd_data, memory_data;

  // fixed-priority instance signals
  logic        req_a_f, req_b_f;
  logic        gnt_a_f, rvalid_a_f, gnt_b_f, rvalid_b_f, wen_f, busy_f;
  logic [31:0] rdata_a_f, rdata_b_f, Mem_Addr_f, RF_Rd_data_f, memory_data_f;
  logic        zero_we = 1'b0;
  logic [31:0] zero_data = 32'd0;
  logic [31:0] addr8 = 32'd8;
  logic [31:0] addr9 = 32'd9;

  logic [31:0] mem [0:31] = '{default: 32'd0};

  int n_chk  = 0;
  int n_pass = 0;

  bit          exp_gnt  [$];   // 0 = A, 1 = B, in grant order
  logic [31:0] exp_rd_a [$];
  logic [31:0] exp_rd_b [$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .Mem_Addr(Mem_Addr), .RF_Rd_data(RF_Rd_data), .wen(wen),
    .memory_data(memory_data), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a_f), .we_a(zero_we), .addr_a(addr8), .wdata_a(zero_data),
    .gnt_a(gnt_a_f), .rvalid_a(rvalid_a_f), .rdata_a(rdata_a_f),
    .req_b(req_b_f), .we_b(zero_we), .addr_b(addr9), .wdata_b(zero_data),
    .gnt_b(gnt_b_f), .rvalid_b(rvalid_b_f), .rdata_b(rdata_b_f),
    .Mem_Addr(Mem_Addr_f), .RF_Rd_data(RF_Rd_data_f), .wen(wen_f),
    .memory_data(memory_data_f), .busy(busy_f)
  );

  // DMEM model: combinational read, write on the rising edge when wen is high
  assign memory_data   = mem[Mem_Addr[4:0]];
  assign memory_data_f = Mem_Addr_f + 32'h100;
  always @(posedge clk) begin
    if (wen) mem[Mem_Addr[4:0]] <= RF_Rd_data;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // scoreboard: pop expectations whenever the DUT emits a grant or read data
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt_a || gnt_b) begin
        check("gnt_onehot", {63'd0, gnt_a & gnt_b}, 64'd0);
        check("gnt_expected", {63'd0, exp_gnt.size() != 0}, 64'd1);
        if (exp_gnt.size() != 0) check("gnt_order", {63'd0, gnt_b}, {63'd0, exp_gnt.pop_front()});
      end
      if (rvalid_a || rvalid_b) begin
        check("rvalid_onehot", {63'd0, rvalid_a & rvalid_b}, 64'd0);
      end
      if (rvalid_a) begin
        check("rd_a_expected", {63'd0, exp_rd_a.size() != 0}, 64'd1);
        if (exp_rd_a.size() != 0) check("rdata_a", {32'd0, rdata_a}, {32'd0, exp_rd_a.pop_front()});
      end
      if (rvalid_b) begin
        check("rd_b_expected", {63'd0, exp_rd_b.size() != 0}, 64'd1);
        if (exp_rd_b.size() != 0) check("rdata_b", {32'd0, rdata_b}, {32'd0, exp_rd_b.pop_front()});
      end
    end
  end

  task automatic wait_gnt(input bit who);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = who ? gnt_b : gnt_a;
    end
    check("gnt_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic access(input bit who, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    if (who) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = data; end
    else     begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = data; end
    exp_gnt.push_back(who);
    if (!we) begin
      if (who) exp_rd_b.push_back(exp_rd); else exp_rd_a.push_back(exp_rd);
    end
    wait_gnt(who);
    check("acc_wen",  {63'd0, wen},  {63'd0, we});
    check("acc_busy", {63'd0, busy}, 64'd1);
    check("acc_addr", {32'd0, Mem_Addr}, {32'd0, addr});
    if (we) check("acc_wdata", {32'd0, RF_Rd_data}, {32'd0, data});
    check("acc_no_rvalid", {63'd0, rvalid_a | rvalid_b}, 64'd0);
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    check("post_wen", {63'd0, wen}, 64'd0);
    check("post_rvalid", {63'd0, who ? rvalid_b : rvalid_a}, {63'd0, !we});
    check("post_addr_hold", {32'd0, Mem_Addr}, {32'd0, addr});
  endtask

  initial begin
    int g, cnt, ca, cb;
    rst_n = 1'b0;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    req_a_f = 0; req_b_f = 0;
    #2;
    // reset state, before any clock edge
    check("rst_gnt",    {62'd0, gnt_a, gnt_b}, 64'd0);
    check("rst_rvalid", {62'd0, rvalid_a, rvalid_b}, 64'd0);
    check("rst_wen_busy", {62'd0, wen, busy}, 64'd0);
    check("rst_addr",   {32'd0, Mem_Addr}, 64'd0);
    check("rst_wdata",  {32'd0, RF_Rd_data}, 64'd0);
    check("rst_rdata",  {rdata_a, rdata_b}, 64'd0);
    #10 rst_n = 1'b1;

    // A writes 511 to 8, then reads it back
    access(1'b0, 1'b1, 32'd8, 32'd511, 32'd0);
    access(1'b0, 1'b0, 32'd8, 32'd0, 32'd511);
    // B writes 103 to 9
    access(1'b1, 1'b1, 32'd9, 32'd103, 32'd0);

    // both read continuously: grants alternate starting with A (B won last)
    @(posedge clk); #1;
    req_a = 1; we_a = 0; addr_a = 8; req_b = 1; we_b = 0; addr_b = 9;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_rd_a.push_back(511); exp_rd_a.push_back(511);
    exp_rd_b.push_back(103); exp_rd_b.push_back(103);
    g = 0;
    for (int i = 0; i < 20 && g < 4; i++) begin
      @(negedge clk);
      if (gnt_a || gnt_b) g++;
    end
    check("rr_grants", g, 4);
    @(posedge clk); #1;
    req_a = 0; req_b = 0;
    @(negedge clk); @(negedge clk);

    // single requester B for 6 cycles: busy 0,1,0,1,0,1 and three grants
    @(posedge clk); #1;
    req_b = 1; we_b = 0; addr_b = 9;
    repeat (3) begin exp_gnt.push_back(1); exp_rd_b.push_back(103); end
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("single_busy", {63'd0, busy}, (i % 2 == 1) ? 64'd1 : 64'd0);
      if (gnt_b) cnt++;
    end
    check("single_gnt_count", cnt, 3);
    @(posedge clk); #1;
    req_b = 0;
    @(negedge clk); @(negedge clk);

    // B writes 999 to 9, reset pulses mid-ACCESS: write must not land
    @(posedge clk); #1;
    req_b = 1; we_b = 1; addr_b = 9; wdata_b = 999;
    exp_gnt.push_back(1);
    wait_gnt(1'b1);
    check("abort_wen_before", {63'd0, wen}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_wen_async", {63'd0, wen}, 64'd0);
    check("abort_busy_async", {63'd0, busy}, 64'd0);
    check("abort_gnt_async", {63'd0, gnt_b}, 64'd0);
    check("abort_addr_clr", {32'd0, Mem_Addr}, 64'd0);
    check("abort_rdata_clr", {rdata_a, rdata_b}, 64'd0);
    req_b = 0; we_b = 0;
    @(negedge clk); #2 rst_n = 1'b1;

    // after reset both request: A first; addr 9 still holds 103
    @(posedge clk); #1;
    req_a = 1; we_a = 0; addr_a = 8; req_b = 1; we_b = 0; addr_b = 9;
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_rd_a.push_back(511); exp_rd_b.push_back(103);
    g = 0;
    for (int i = 0; i < 20 && g < 2; i++) begin
      @(negedge clk);
      if (gnt_a || gnt_b) g++;
    end
    check("post_rst_grants", g, 2);
    @(posedge clk); #1;
    req_a = 0; req_b = 0;
    @(negedge clk); @(negedge clk);

    // fixed priority: B never wins while A keeps requesting
    @(posedge clk); #1;
    req_a_f = 1; req_b_f = 1;
    ca = 0; cb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt_a_f) ca++;
      if (gnt_b_f) cb++;
      if (rvalid_a_f) check("fp_rdata_a", {32'd0, rdata_a_f}, 64'h108);
    end
    check("fp_a_grants", ca, 4);
    check("fp_b_grants", cb, 0);
    @(posedge clk); #1;
    req_a_f = 0;
    cb = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (gnt_b_f) cb++;
    end
    check("fp_b_alone", cb, 1);
    @(posedge clk); #1;
    req_b_f = 0;
    @(negedge clk); @(negedge clk);

    // every expectation must have been consumed
    check("left_gnt",  exp_gnt.size(),  0);
    check("left_rd_a", exp_rd_a.size(), 0);
    check("left_rd_b", exp_rd_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
